sample_capture: RTL and testbench
=================================

SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 Parameter WIDTH, default 12, sample width in bits (two's complement).
REQ-002 Parameter DEPTH, default 16, buffer depth in samples; power of two, at least 4.
REQ-003 Parameter STOP_ON_FULL, default 0; when 1, capture halts on the first dropped sample.
REQ-004 Port clk  in  1  single clock; all logic on the rising edge.
REQ-005 Port rst  in  1  reset; synchronous, active-high.
REQ-006 Port din  in  WIDTH  filter output sample.
REQ-007 Port vin  in  1  din valid, one sample per asserted cycle.
REQ-008 Port start  in  1  pulse; arm capture.
REQ-009 Port stop  in  1  pulse; halt capture.
REQ-010 Port rd_en  in  1  host read request.
REQ-011 Port dout  out  WIDTH  read data.
REQ-012 Port vout  out  1  dout valid.
REQ-013 Port count  out  log2(DEPTH)+1  stored-sample count.
REQ-014 Port empty, full  out  1 each  buffer status, combinational from count.
REQ-015 Port ovf  out  1  sticky overflow (sample dropped).
REQ-016 Port running  out  1  high in RUN state.
REQ-017 Port peak  out  WIDTH  largest |sample| captured (see Configuration).

Function
REQ-018 The FSM SHALL have the states IDLE, RUN and HALT; IDLE -> RUN on start; RUN -> HALT on stop; HALT -> RUN on start; no other transitions except reset.
REQ-019 When start and stop are asserted in the same cycle, stop SHALL win: RUN -> HALT, IDLE and HALT unchanged.
REQ-020 A sample SHALL be written only when state is RUN, vin=1 and (full=0 or an accepted read occurs in the same cycle).
REQ-021 RUN, vin=1, full=1, rd_en=0: sample dropped, ovf set next cycle; if STOP_ON_FULL=1 the state also goes to HALT next cycle.
REQ-022 A read SHALL be accepted when rd_en=1 and empty=0; dout holds the oldest sample and vout=1 on the next cycle, with a latency of 1.
REQ-023 rd_en with empty=1 SHALL be ignored: vout=0 next cycle, dout holds its value, no error flag is raised.
REQ-024 Same-cycle write and read with empty=1: the write is accepted and the read ignored.
REQ-025 Same-cycle write and read with 0<count<DEPTH: count is unchanged, FIFO order is preserved.
REQ-026 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL equal the writes minus the reads.
REQ-027 vout SHALL be a one-cycle pulse per accepted read.
REQ-028 A start accepted from IDLE or HALT SHALL clear ovf and peak but SHALL NOT flush the buffer.
REQ-029 Reads SHALL be served in every state, so the buffer can be drained after HALT.

Reset
REQ-030 On rst=1 at a clock edge: state IDLE, pointers 0, count 0, empty 1, full 0, ovf 0, running 0, vout 0, dout 0, peak 0.
REQ-031 A reset in mid-operation SHALL discard all buffered samples; a read pending in that cycle SHALL produce no vout.
REQ-032 rst SHALL have priority over start, stop, vin and rd_en.

Configuration
REQ-033 Macro SAMPLE_CAPTURE_PEAK_EN defined: peak SHALL be updated on each accepted write to max(peak, |din|); |-2^(WIDTH-1)| saturates to 2^(WIDTH-1)-1.
REQ-034 Macro SAMPLE_CAPTURE_PEAK_EN undefined: peak SHALL be tied to 0 and no peak register is synthesized.

Structure
REQ-035 Package sample_capture_pkg SHALL hold the WIDTH/DEPTH defaults, the state encoding (IDLE, RUN, HALT) and the count-width function.
REQ-036 Sub-module sample_capture_mem SHALL implement the DEPTH x WIDTH register array with one write port and one registered read port; the FSM, pointers and flags live in sample_capture.

Verification
REQ-037 Reset, start, 5 samples 1,2,3,4,5 with vin=1, then 5 rd_en -> dout 1..5, each with a vout pulse, count 5->0, empty=1.
REQ-038 Start, 17 consecutive samples 0..16 (DEPTH=16), no reads -> full=1 after 16, sample 16 dropped, ovf=1, draining returns 0..15.
REQ-039 As REQ-038 with STOP_ON_FULL=1 -> running=0 one cycle after the drop, later vin ignored, ovf=1.
REQ-040 Full buffer, vin=1 and rd_en=1 together for 20 cycles -> count stays 16, ovf=0, output order is continuous across pointer wrap.
REQ-041 Start and stop in the same cycle from IDLE -> state stays IDLE, running=0; vin samples ignored, count 0.
REQ-042 With SAMPLE_CAPTURE_PEAK_EN, samples 100, -2048, 7 -> peak=2047; reset mid-stream -> peak=0, count=0, no vout.

Source files
------------

// File: rtl/sample_capture_pkg.sv
// sample_capture_pkg -- shared definitions for the sample capture block.
//   DEF_WIDTH / DEF_DEPTH : default sample width and buffer depth
//   state_t               : capture FSM encoding (IDLE, RUN, HALT)
//   cnt_w()               : width of the stored-sample count, log2(depth)+1
package sample_capture_pkg;

    localparam int DEF_WIDTH = 12;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // One extra bit so the count can represent a completely full buffer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_capture_if.sv
// sample_capture_if -- sample/control/host-read bundle for sample_capture.
//   master : the source/host side (drives din, vin, start, stop, rd_en)
//   slave  : the capture block (drives dout, vout, count, empty, full,
//            ovf, running, peak)
interface sample_capture_if
    import sample_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    logic [WIDTH-1:0]        din;
    logic                    vin;
    logic                    start;
    logic                    stop;
    logic                    rd_en;
    logic [WIDTH-1:0]        dout;
    logic                    vout;
    logic [cnt_w(DEPTH)-1:0] count;
    logic                    empty;
    logic                    full;
    logic                    ovf;
    logic                    running;
    logic [WIDTH-1:0]        peak;

    modport master (
        output din, vin, start, stop, rd_en,
        input  dout, vout, count, empty, full, ovf, running, peak
    );

    modport slave (
        input  din, vin, start, stop, rd_en,
        output dout, vout, count, empty, full, ovf, running, peak
    );
endinterface

// File: rtl/sample_capture_mem.sv
// sample_capture_mem -- DEPTH x WIDTH sample storage.
//   clk, rst        : clock, synchronous active-high reset (read register only)
//   we/waddr/wdata  : write port
//   re/raddr/rdata  : registered read port, rdata updates one cycle after re
// A read and write to the same address in one cycle returns the old word,
// which is what a full buffer with simultaneous write+read needs.
module sample_capture_mem
    import sample_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is not reset; validity is tracked by the pointers in the top.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sample_capture.sv
// sample_capture -- arms on start, buffers valid filter samples into a FIFO
// while running, and lets the host drain it in any state.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sample_capture_if.slave (din/vin in, start/stop control,
//              rd_en host read, dout/vout read data, count/empty/full/ovf/
//              running status, peak magnitude)
//   STOP_ON_FULL : 1 = halt capture on the first dropped sample
// Optional feature: define SAMPLE_CAPTURE_PEAK_EN to track the largest
// |sample| written; otherwise peak reads 0 and no register is built.
// DEPTH must be a power of two (>= 4) so the pointers wrap naturally.
module sample_capture
    import sample_capture_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter bit STOP_ON_FULL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    sample_capture_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          ovf_q, vout_q;
    logic          empty, full;
    logic          rd_acc, wr_acc, drop, start_acc;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

    // A read frees a slot in the same cycle, so a full buffer still
    // accepts a write when a read is accepted alongside it.
    assign rd_acc = bus.rd_en && !empty;
    assign wr_acc = (state == RUN) && bus.vin && (!full || rd_acc);
    assign drop   = (state == RUN) && bus.vin && full && !rd_acc;

    // Stop beats start; start is only meaningful outside RUN.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (bus.start && !bus.stop) begin
                    state_nxt = RUN;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop || (drop && STOP_ON_FULL)) state_nxt = HALT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            vout_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            vout_q <= rd_acc;
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            // start_acc and drop are exclusive: drop needs RUN, start_acc does not.
            if (start_acc) ovf_q <= 1'b0;
            else if (drop) ovf_q <= 1'b1;
        end
    end

    sample_capture_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc && !rst),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (bus.dout)
    );

`ifdef SAMPLE_CAPTURE_PEAK_EN
    logic [WIDTH-1:0] peak_q, din_abs;

    // Most-negative input has no positive twin; clamp it to the max positive.
    always_comb begin
        din_abs = bus.din;
        if (bus.din[WIDTH-1]) begin
            if (bus.din == {1'b1, {(WIDTH-1){1'b0}}}) din_abs = {1'b0, {(WIDTH-1){1'b1}}};
            else                                       din_abs = (~bus.din) + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                               peak_q <= '0;
        else if (start_acc)                    peak_q <= '0;
        else if (wr_acc && (din_abs > peak_q)) peak_q <= din_abs;
    end

    assign bus.peak = peak_q;
`else
    assign bus.peak = '0;
`endif

    assign bus.vout    = vout_q;
    assign bus.count   = cnt;
    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.ovf     = ovf_q;
    assign bus.running = (state == RUN);
endmodule

// File: tb/tb_sample_capture.sv
// tb_sample_capture -- directed bench for sample_capture. Two instances share
// one stimulus stream: dut_a with STOP_ON_FULL=0, dut_b with STOP_ON_FULL=1.
// A queue-based model predicts every output each cycle; literal expectations
// pin the read-back sequences and key status points.
// Honors SAMPLE_CAPTURE_PEAK_EN for the expected peak value.
module tb_sample_capture;
    import sample_capture_pkg::*;

    localparam int W = 12;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sample_capture_if #(.WIDTH(W), .DEPTH(D)) ia ();
    sample_capture_if #(.WIDTH(W), .DEPTH(D)) ib ();

    assign ib.din   = ia.din;
    assign ib.vin   = ia.vin;
    assign ib.start = ia.start;
    assign ib.stop  = ia.stop;
    assign ib.rd_en = ia.rd_en;

    sample_capture #(.WIDTH(W), .DEPTH(D), .STOP_ON_FULL(1'b0)) dut_a (
        .clk (clk), .rst (rst), .bus (ia.slave)
    );
    sample_capture #(.WIDTH(W), .DEPTH(D), .STOP_ON_FULL(1'b1)) dut_b (
        .clk (clk), .rst (rst), .bus (ib.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // ---------------- model ----------------
    // st: 0 idle, 1 running, 2 halted
    int         m_st   [2];
    int         m_ovf  [2];
    int         m_peak [2];
    int         m_vout [2];
    int         m_dout [2];
    bit         m_live = 1'b0;
    logic [W-1:0] q0[$], q1[$];

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int qpop(input int k);
        if (k == 0) return int'(q0.pop_front());
        return int'(q1.pop_front());
    endfunction

    function automatic void qpush(input int k, input logic [W-1:0] v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endfunction

    function automatic int mag(input logic [W-1:0] v);
        int s;
        s = int'($signed(v));
        if (s >= 0) return s;
        if (s == -(1 << (W-1))) return (1 << (W-1)) - 1;
        return -s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1;
            q0.delete();
            q1.delete();
            for (int k = 0; k < 2; k++) begin
                m_st[k] = 0; m_ovf[k] = 0; m_peak[k] = 0; m_vout[k] = 0; m_dout[k] = 0;
            end
        end else if (m_live) begin
            for (int k = 0; k < 2; k++) begin
                int  n;
                bit  rd, runv, wr, drp;
                n    = qsize(k);
                rd   = ia.rd_en && (n > 0);
                runv = (m_st[k] == 1) && ia.vin;
                wr   = runv && ((n < D) || rd);
                drp  = runv && (n == D) && !rd;
                m_vout[k] = rd ? 1 : 0;
                if (rd) m_dout[k] = qpop(k);
                if (wr) begin
                    qpush(k, ia.din);
                    if (mag(ia.din) > m_peak[k]) m_peak[k] = mag(ia.din);
                end
                if (drp) m_ovf[k] = 1;
                if (ia.stop) begin
                    if (m_st[k] == 1) m_st[k] = 2;
                end else if (ia.start && (m_st[k] != 1)) begin
                    m_st[k] = 1; m_ovf[k] = 0; m_peak[k] = 0;
                end else if (drp && (k == 1)) begin
                    m_st[k] = 2;
                end
            end
        end
    end

    // ---------------- compare + read capture ----------------
    string nms [8] = '{"vout", "dout", "count", "empty", "full", "ovf", "running", "peak"};
    int    act [2][8];
    int    ex  [2][8];
    int    ga[$], gb[$];

    always @(negedge clk) begin
        if (m_live) begin
            act[0] = '{int'(ia.vout), int'(ia.dout), int'(ia.count), int'(ia.empty),
                       int'(ia.full), int'(ia.ovf), int'(ia.running), int'(ia.peak)};
            act[1] = '{int'(ib.vout), int'(ib.dout), int'(ib.count), int'(ib.empty),
                       int'(ib.full), int'(ib.ovf), int'(ib.running), int'(ib.peak)};
            for (int k = 0; k < 2; k++) begin
                ex[k][0] = m_vout[k];
                ex[k][1] = m_dout[k];
                ex[k][2] = qsize(k);
                ex[k][3] = (qsize(k) == 0) ? 1 : 0;
                ex[k][4] = (qsize(k) == D) ? 1 : 0;
                ex[k][5] = m_ovf[k];
                ex[k][6] = (m_st[k] == 1) ? 1 : 0;
`ifdef SAMPLE_CAPTURE_PEAK_EN
                ex[k][7] = m_peak[k];
`else
                ex[k][7] = 0;
`endif
                for (int j = 0; j < 8; j++)
                    chk($sformatf("model_%s[%0d] t=%0t", nms[j], k, $time), act[k][j], ex[k][j]);
            end
            if (ia.vout) ga.push_back(int'(ia.dout));
            if (ib.vout) gb.push_back(int'(ib.dout));
        end
    end

    // ---------------- literal helpers ----------------
    function automatic int gget(input int k, input int i);
        if (k == 0) return (i < ga.size()) ? ga[i] : -1;
        return (i < gb.size()) ? gb[i] : -1;
    endfunction

    task automatic chk_seq(input string nm, input int k, input int off, input int first, input int n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", nm, off + i), gget(k, off + i), first + i);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        ga.delete();
        gb.delete();
    endtask

    task automatic pulse_start();
        ia.start = 1'b1;
        step(1);
        ia.start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ia.din = '0; ia.vin = 1'b0; ia.start = 1'b0; ia.stop = 1'b0; ia.rd_en = 1'b0;
        rst = 1'b1;
        step(2);
        chk("rst_count", int'(ia.count), 0);
        chk("rst_empty", int'(ia.empty), 1);
        chk("rst_full", int'(ia.full), 0);
        chk("rst_dout", int'(ia.dout), 0);
        chk("rst_running", int'(ia.running), 0);
        rst = 1'b0;

        // Read on empty buffer is ignored.
        ia.rd_en = 1'b1;
        step(1);
        ia.rd_en = 1'b0;
        chk("empty_rd_vout", int'(ia.vout), 0);

        // Basic FIFO: 1..5 in, 1..5 out; first write overlaps a read on empty.
        pulse_start();
        chk("s1_running", int'(ia.running), 1);
        for (int i = 1; i <= 5; i++) begin
            ia.din = W'(i); ia.vin = 1'b1; ia.rd_en = (i == 1);
            step(1);
            if (i == 1) begin
                chk("wr_rd_empty_count", int'(ia.count), 1);
                chk("wr_rd_empty_vout", int'(ia.vout), 0);
            end
        end
        ia.vin = 1'b0; ia.rd_en = 1'b0;
        chk("s1_count5", int'(ia.count), 5);
        ia.rd_en = 1'b1;
        step(5);
        ia.rd_en = 1'b0;
        step(1);
        chk("s1_n", ga.size(), 5);
        chk_seq("s1_a", 0, 0, 1, 5);
        chk_seq("s1_b", 1, 0, 1, 5);
        chk("s1_count0", int'(ia.count), 0);
        chk("s1_empty", int'(ia.empty), 1);

        // Overflow: 17 samples into 16 slots; dut_b halts on the drop.
        do_reset();
        pulse_start();
        for (int i = 0; i <= 16; i++) begin
            ia.din = W'(i); ia.vin = 1'b1;
            step(1);
            if (i == 15) begin
                chk("s2_full", int'(ia.full), 1);
                chk("s2_ovf_pre", int'(ia.ovf), 0);
            end
        end
        ia.vin = 1'b0;
        chk("s2_a_ovf", int'(ia.ovf), 1);
        chk("s2_a_running", int'(ia.running), 1);
        chk("s2_b_ovf", int'(ib.ovf), 1);
        chk("s2_b_running", int'(ib.running), 0);
        chk("s2_b_count", int'(ib.count), 16);
        ia.rd_en = 1'b1;
        step(2);
        ia.rd_en = 1'b0;
        ia.vin = 1'b1; ia.din = W'(200);
        step(1);
        ia.din = W'(201);
        step(1);
        ia.vin = 1'b0;
        chk("s2_a_count_refill", int'(ia.count), 16);
        chk("s2_b_count_ignored", int'(ib.count), 14);
        // stop then start: ovf cleared, buffer kept
        ia.stop = 1'b1;
        step(1);
        ia.stop = 1'b0;
        pulse_start();
        chk("s2_a_ovf_clr", int'(ia.ovf), 0);
        chk("s2_b_ovf_clr", int'(ib.ovf), 0);
        chk("s2_b_rerun", int'(ib.running), 1);
        chk("s2_b_kept", int'(ib.count), 14);
        ia.rd_en = 1'b1;
        step(16);
        ia.rd_en = 1'b0;
        step(1);
        chk("s2_a_n", ga.size(), 18);
        chk_seq("s2_a", 0, 0, 0, 16);
        chk("s2_a_tail0", gget(0, 16), 200);
        chk("s2_a_tail1", gget(0, 17), 201);
        chk("s2_b_n", gb.size(), 16);
        chk_seq("s2_b", 1, 0, 0, 16);

        // Full buffer with simultaneous write+read across pointer wrap.
        do_reset();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            ia.din = W'(100 + i); ia.vin = 1'b1;
            step(1);
        end
        for (int i = 0; i < 20; i++) begin
            ia.din = W'(116 + i); ia.vin = 1'b1; ia.rd_en = 1'b1;
            step(1);
            chk("s3_count", int'(ia.count), 16);
        end
        ia.vin = 1'b0;
        chk("s3_ovf", int'(ia.ovf), 0);
        step(16);
        ia.rd_en = 1'b0;
        step(1);
        chk("s3_n", ga.size(), 36);
        chk_seq("s3_a", 0, 0, 100, 36);
        chk_seq("s3_b", 1, 0, 100, 36);

        // start+stop together from IDLE: stay idle, samples ignored.
        do_reset();
        ia.start = 1'b1; ia.stop = 1'b1;
        step(1);
        ia.start = 1'b0; ia.stop = 1'b0;
        chk("s4_running", int'(ia.running), 0);
        ia.vin = 1'b1; ia.din = W'(5);
        step(3);
        ia.vin = 1'b0;
        chk("s4_count", int'(ia.count), 0);

        // Peak with most-negative sample, then reset mid-stream with a read pending.
        do_reset();
        pulse_start();
        ia.vin = 1'b1;
        ia.din = W'(100);   step(1);
        ia.din = 12'h800;   step(1);
        ia.din = W'(7);     step(1);
        ia.vin = 1'b0;
`ifdef SAMPLE_CAPTURE_PEAK_EN
        chk("s5_peak", int'(ia.peak), 2047);
`else
        chk("s5_peak", int'(ia.peak), 0);
`endif
        ia.vin = 1'b1; ia.din = W'(50); ia.rd_en = 1'b1;
        step(1);
        rst = 1'b1;
        step(1);
        chk("s5_rst_vout", int'(ia.vout), 0);
        chk("s5_rst_count", int'(ia.count), 0);
        chk("s5_rst_peak", int'(ia.peak), 0);
        rst = 1'b0; ia.vin = 1'b0; ia.rd_en = 1'b0;
        step(2);
        chk("s5_post_vout", int'(ia.vout), 0);
        chk("s5_post_empty", int'(ia.empty), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
